// File: rtl/vnclip_sat_pipe.sv
// vnclip_sat_pipe: two-stage narrowing shift/round/saturate clip unit; optional VNCLIP_SAT_CNT_EN adds a saturation counter port
module vnclip_sat_pipe #(
    parameter int LANES   = 4,
    parameter int W_IN    = 16,
    parameter int W_OUT   = 8,
    parameter int SHIFT_W = $clog2(W_IN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*W_IN-1:0]  in_data,
    input  logic [SHIFT_W-1:0]     in_shift,
    input  logic [1:0]             in_vxrm,
    input  logic                   in_signed,
    input  logic [LANES-1:0]       in_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*W_OUT-1:0] out_data,
    output logic [LANES-1:0]       out_sat,
    output logic                   vxsat,
`ifdef VNCLIP_SAT_CNT_EN
    output logic [15:0]            sat_cnt,
`endif
    input  logic                   vxsat_clr
);
    localparam int WQ = W_IN + 1;
    logic                   s1_valid, s1_signed, s1_load, s2_load, hs;
    logic [LANES-1:0]       s1_mask, sat_d;
    logic [WQ-1:0]          rnd  [LANES];
    logic [WQ-1:0]          s1_q [LANES];
    logic [LANES*W_OUT-1:0] data_d;
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;
    assign hs       = out_valid && out_ready;
    genvar i;
    for (i = 0; i < LANES; i++) begin : g_lane
        logic [WQ-1:0]    v, q, m0, m1;
        logic             bd1, bd, r, neg, sat;
        logic [W_OUT-1:0] lim;
        assign v   = {in_signed & in_data[i*W_IN+W_IN-1], in_data[i*W_IN +: W_IN]};
        assign q   = $signed(v) >>> in_shift;
        assign m0  = (WQ'(1) << in_shift) - WQ'(1);
        assign m1  = m0 >> 1;
        assign bd1 = |(v & (m0 ^ m1));
        assign bd  = |(v & (m0 + WQ'(1)));
        assign r   = in_vxrm == 2'd0 ? bd1 :
                     in_vxrm == 2'd1 ? bd1 & ((|(v & m1)) | bd) :
                     in_vxrm == 2'd2 ? 1'b0 : !bd & (|(v & m0));
        assign rnd[i] = q + WQ'(r);
        assign neg = s1_q[i][WQ-1];
        assign sat = s1_signed ? !((&s1_q[i][WQ-1:W_OUT-1]) || !(|s1_q[i][WQ-1:W_OUT-1]))
                               : |s1_q[i][WQ-1:W_OUT];
        assign lim = s1_signed ? {neg, {(W_OUT-1){!neg}}} : '1;
        assign sat_d[i] = s1_mask[i] & sat;
        assign data_d[i*W_OUT +: W_OUT] = !s1_mask[i] ? '0 : sat ? lim : s1_q[i][W_OUT-1:0];
    end
    // S1: capture rounded shift results and beat controls
    always_ff @(posedge clk) begin
        if (rst) s1_valid <= 1'b0;
        else if (s1_load) s1_valid <= in_valid;
        if (s1_load && in_valid) begin
            s1_q      <= rnd;
            s1_signed <= in_signed;
            s1_mask   <= in_mask;
        end
    end
    // S2: register saturated lanes, held while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= data_d;
                out_sat  <= sat_d;
            end
        end
    end
    // sticky saturation flag, a saturating handshake beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) vxsat <= 1'b0;
        else if (hs && |out_sat) vxsat <= 1'b1;
        else if (vxsat_clr) vxsat <= 1'b0;
    end
`ifdef VNCLIP_SAT_CNT_EN
    localparam int PW = $clog2(LANES + 1);
    logic [PW-1:0] pc;
    logic [16:0]   cnt_sum;
    // popcount of lanes saturated in the presented beat
    always_comb begin
        pc = '0;
        for (int k = 0; k < LANES; k++) pc = pc + PW'(out_sat[k]);
    end
    assign cnt_sum = {1'b0, sat_cnt} + 17'(pc);
    // saturating count of saturated lanes over handshakes
    always_ff @(posedge clk) begin
        if (rst) sat_cnt <= '0;
        else if (hs && |out_sat) sat_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        else if (vxsat_clr) sat_cnt <= '0;
    end
`endif
endmodule

// File: tb/tb_vnclip_sat_pipe.sv
// tb_vnclip_sat_pipe: directed checks of clip, rounding, masking, backpressure, vxsat and reset
module tb_vnclip_sat_pipe;
    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 1, in_signed = 0, vxsat_clr = 0;
    logic [63:0] in_data = '0;
    logic [3:0]  in_shift = '0, in_mask = '0;
    logic [1:0]  in_vxrm = '0;
    wire         in_ready, out_valid, vxsat;
    wire  [31:0] out_data;
    wire  [3:0]  out_sat;
`ifdef VNCLIP_SAT_CNT_EN
    wire  [15:0] sat_cnt;
`endif
    int tests = 0, fails = 0;

    vnclip_sat_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shift(in_shift), .in_vxrm(in_vxrm), .in_signed(in_signed), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .vxsat(vxsat),
`ifdef VNCLIP_SAT_CNT_EN
        .sat_cnt(sat_cnt),
`endif
        .vxsat_clr(vxsat_clr)
    );

    always #5 clk = ~clk;

    task automatic set_beat(input logic [63:0] d, input logic [3:0] sh, input logic [1:0] rm,
                            input logic sg, input logic [3:0] mk);
        in_data = d; in_shift = sh; in_vxrm = rm; in_signed = sg; in_mask = mk;
    endtask

    task automatic run_beat(input logic [63:0] d, input logic [3:0] sh, input logic [1:0] rm,
                            input logic sg, input logic [3:0] mk, output int lat);
        @(negedge clk);
        set_beat(d, sh, rm, sg, mk);
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic logic [63:0] bdat(input int k);
        return {16'(k*4+4), 16'(k*4+3), 16'(k*4+2), 16'(k*4+1)};
    endfunction

    function automatic logic [31:0] bexp(input int k);
        return {8'(k*4+4), 8'(k*4+3), 8'(k*4+2), 8'(k*4+1)};
    endfunction

    task automatic test_reset;
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        tests++; if (out_sat !== 4'h0) begin fails++; $display("FAIL reset_out_sat: got %b want 0", out_sat); end
        tests++; if (vxsat !== 1'b0) begin fails++; $display("FAIL reset_vxsat: got %b want 0", vxsat); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_signed_sat;
        int lat;
        run_beat({16'hFF80, 16'h0042, 16'hFF00, 16'h0100}, 4'd0, 2'd0, 1'b1, 4'hF, lat);
        tests++; if (lat !== 2) begin fails++; $display("FAIL sat_latency: got %0d want 2", lat); end
        tests++; if (out_data !== 32'h8042807F) begin fails++; $display("FAIL sat_data: got %h want 8042807f", out_data); end
        tests++; if (out_sat !== 4'b0011) begin fails++; $display("FAIL sat_flags: got %b want 0011", out_sat); end
        tests++; if (vxsat !== 1'b0) begin fails++; $display("FAIL sat_vxsat_pre: got %b want 0", vxsat); end
        @(negedge clk);
        tests++; if (vxsat !== 1'b1) begin fails++; $display("FAIL sat_vxsat_set: got %b want 1", vxsat); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sat_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_rounding;
        logic [7:0] e0 [4] = '{8'h03, 8'h02, 8'h02, 8'h03};
        logic [7:0] e1 [4] = '{8'hFE, 8'hFE, 8'hFD, 8'hFD};
        int lat;
        for (int rm = 0; rm < 4; rm++) begin
            run_beat({16'h0000, 16'h0000, 16'hFFF6, 16'h000A}, 4'd2, 2'(rm), 1'b1, 4'hF, lat);
            tests++; if (lat !== 2) begin fails++; $display("FAIL round_latency vxrm=%0d: got %0d want 2", rm, lat); end
            tests++;
            if (out_data !== {16'h0000, e1[rm], e0[rm]}) begin
                fails++; $display("FAIL round_data vxrm=%0d: got %h want %h", rm, out_data, {16'h0000, e1[rm], e0[rm]});
            end
            tests++; if (out_sat !== 4'h0) begin fails++; $display("FAIL round_sat vxrm=%0d: got %b want 0", rm, out_sat); end
        end
    endtask

    task automatic test_unsigned_mask;
        int lat;
        run_beat({16'hFFFF, 16'h01FE, 16'h0300, 16'h0300}, 4'd1, 2'd0, 1'b0, 4'b1110, lat);
        tests++; if (out_data !== 32'hFFFFFF00) begin fails++; $display("FAIL unsigned_data: got %h want ffffff00", out_data); end
        tests++; if (out_sat !== 4'b1010) begin fails++; $display("FAIL unsigned_sat: got %b want 1010", out_sat); end
    endtask

    task automatic test_vxsat_clr;
        int lat;
        @(negedge clk);
        vxsat_clr = 1;
        @(negedge clk);
        vxsat_clr = 0;
        tests++; if (vxsat !== 1'b0) begin fails++; $display("FAIL clr_alone: got %b want 0", vxsat); end
        run_beat({4{16'h0001}}, 4'd0, 2'd0, 1'b1, 4'hF, lat);
        @(negedge clk);
        tests++; if (vxsat !== 1'b0) begin fails++; $display("FAIL clr_nonsat_hs: got %b want 0", vxsat); end
        run_beat({4{16'h7FFF}}, 4'd0, 2'd0, 1'b1, 4'hF, lat);
        tests++; if (out_sat !== 4'hF) begin fails++; $display("FAIL clr_beat_sat: got %b want 1111", out_sat); end
        vxsat_clr = 1;
        @(negedge clk);
        tests++; if (vxsat !== 1'b1) begin fails++; $display("FAIL clr_set_wins: got %b want 1", vxsat); end
        @(negedge clk);
        vxsat_clr = 0;
        tests++; if (vxsat !== 1'b0) begin fails++; $display("FAIL clr_after: got %b want 0", vxsat); end
    endtask

    task automatic test_back_to_back;
        int acc = 0, nout = 0, cyc = 0;
        @(negedge clk);
        out_ready = 0;
        repeat (6) begin
            set_beat(bdat(acc), 4'd0, 2'd0, 1'b1, 4'hF);
            in_valid = 1;
            #1;
            if (in_ready) acc++;
            @(negedge clk);
        end
        tests++; if (acc !== 2) begin fails++; $display("FAIL b2b_accepted_stall: got %0d want 2", acc); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_in_ready_stall: got %b want 0", in_ready); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_held_valid: got %b want 1", out_valid); end
        tests++; if (out_data !== bexp(0)) begin fails++; $display("FAIL b2b_held_data: got %h want %h", out_data, bexp(0)); end
        out_ready = 1;
        while (nout < 5 && cyc < 40) begin
            if (out_valid) begin
                tests++;
                if (out_data !== bexp(nout)) begin fails++; $display("FAIL b2b_order beat %0d: got %h want %h", nout, out_data, bexp(nout)); end
                nout++;
            end
            in_valid = acc < 5;
            set_beat(bdat(acc), 4'd0, 2'd0, 1'b1, 4'hF);
            #1;
            if (in_valid && in_ready) acc++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 0;
        tests++; if (nout !== 5) begin fails++; $display("FAIL b2b_count: got %0d want 5", nout); end
        tests++; if (acc !== 5) begin fails++; $display("FAIL b2b_accepted: got %0d want 5", acc); end
        repeat (3) @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_no_dup: got %b want 0", out_valid); end
    endtask

    task automatic test_rst_mid;
        int lat, seen = 0;
        run_beat({4{16'h7FFF}}, 4'd0, 2'd0, 1'b1, 4'hF, lat);
        @(negedge clk);
        tests++; if (vxsat !== 1'b1) begin fails++; $display("FAIL rst_pre_vxsat: got %b want 1", vxsat); end
        out_ready = 0;
        set_beat({4{16'h8000}}, 4'd0, 2'd0, 1'b1, 4'hF);
        in_valid = 1;
        repeat (2) @(negedge clk);
        in_valid = 0;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_pipe_full: got %b want 0", in_ready); end
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
        tests++; if (vxsat !== 1'b0) begin fails++; $display("FAIL rst_mid_vxsat: got %b want 0", vxsat); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
        out_ready = 1;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL rst_stale_beat: got %0d want 0", seen); end
    endtask

    initial begin
        test_reset;
        test_signed_sat;
        test_rounding;
        test_unsigned_mask;
        test_vxsat_clr;
        test_back_to_back;
        test_rst_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
